id_ctrl_pipe: RTL and testbench

Registered, hazard-aware successor to the combinational main control unit. Decodes a 32-bit RV32I instruction from the IF/ID boundary into the ALU and memory control bundle and registers it into the ID/EX pipeline register. Adds valid tracking, load-use stall generation, flush, downstream back-pressure and illegal-instruction detection. Sits between instruction fetch and the execute stage of the pipelined datapath.

---
 rtl/id_ctrl_pipe.sv | 189 ++++++++++++++++++
 tb/tb_id_ctrl_pipe.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ctrl_pipe.sv
// RV32I main control decode registered into the ID/EX pipeline register, with
// load-use stall generation, flush, downstream back-pressure and illegal-instruction detection.
module id_ctrl_pipe #(
    parameter bit HAZARD_EN      = 1'b1,
    parameter bit STICKY_ILLEGAL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_in,
    input  logic        instr_valid,
    input  logic        flush,
    input  logic        stall_in,
    output logic        stall_out,
    output logic        ex_valid,
    output logic [3:0]  ex_alucontrol,
    output logic        ex_alusrc,
    output logic        ex_memtoreg,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        ex_branch,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [2:0]  ex_funct3,
    output logic        illegal_flag
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef struct packed {
        logic       valid;
        logic [3:0] alucontrol;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
    } ctrl_t;

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       bit30;

    assign opcode = instr_in[6:0];
    assign rd     = instr_in[11:7];
    assign funct3 = instr_in[14:12];
    assign rs1    = instr_in[19:15];
    assign rs2    = instr_in[24:20];
    assign funct7 = instr_in[31:25];
    assign bit30  = instr_in[30];

    // alt selects SUB over ADD and SRA over SRL
    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_sel = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_sel = ALU_SLL;
            3'b010:  alu_sel = ALU_SLT;
            3'b011:  alu_sel = ALU_SLTU;
            3'b100:  alu_sel = ALU_XOR;
            3'b101:  alu_sel = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_sel = ALU_OR;
            default: alu_sel = ALU_AND;
        endcase
    endfunction

    ctrl_t dec, ex_q;
    logic  legal, use_rs1, use_rs2, writes;

    always_comb begin
        dec            = '0;
        legal          = 1'b0;
        use_rs1        = 1'b0;
        use_rs2        = 1'b0;
        writes         = 1'b0;
        dec.valid      = 1'b1;
        dec.alucontrol = ALU_ADD;
        dec.rd         = rd;
        dec.rs1        = rs1;
        dec.rs2        = rs2;
        dec.funct3     = funct3;
        case (opcode)
            OP_R: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                writes  = 1'b1;
                legal   = (funct7 == 7'h00) ||
                          (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
                dec.alucontrol = alu_sel(funct3, bit30);
            end
            OP_I: begin
                use_rs1    = 1'b1;
                writes     = 1'b1;
                dec.alusrc = 1'b1;
                // funct7 is immediate except for the shifts
                if (funct3 == 3'b001)
                    legal = (funct7 == 7'h00);
                else if (funct3 == 3'b101)
                    legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                else
                    legal = 1'b1;
                dec.alucontrol = alu_sel(funct3, bit30 && funct3 == 3'b101);
            end
            OP_LOAD: begin
                use_rs1      = 1'b1;
                writes       = 1'b1;
                dec.alusrc   = 1'b1;
                dec.memread  = 1'b1;
                dec.memtoreg = 1'b1;
                legal = !(funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
            end
            OP_STORE: begin
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
                legal        = (funct3 <= 3'b010);
            end
            OP_BRANCH: begin
                use_rs1        = 1'b1;
                use_rs2        = 1'b1;
                dec.branch     = 1'b1;
                dec.alucontrol = ALU_SUB;
                legal          = !(funct3 == 3'b010 || funct3 == 3'b011);
            end
            default: legal = 1'b0;
        endcase
        dec.regwrite = writes && (rd != 5'd0);
    end

    logic hazard, load_ok, ill_new;

    assign hazard = HAZARD_EN && ex_q.valid && ex_q.memread && (ex_q.rd != 5'd0) &&
                    instr_valid &&
                    ((use_rs1 && ex_q.rd == rs1) || (use_rs2 && ex_q.rd == rs2));
    // a held EX stage is never checked against, so stall_in masks the request
    assign stall_out = hazard && !stall_in && !rst;
    assign load_ok   = instr_valid && legal;
    assign ill_new   = instr_valid && !legal && !flush && !stall_in && !hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q         <= '0;
            illegal_flag <= 1'b0;
        end else begin
            if (flush || (!stall_in && (hazard || !load_ok)))
                ex_q <= '0;
            else if (!stall_in)
                ex_q <= dec;
            illegal_flag <= STICKY_ILLEGAL ? (illegal_flag || ill_new) : ill_new;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_alucontrol = ex_q.alucontrol;
    assign ex_alusrc     = ex_q.alusrc;
    assign ex_memtoreg   = ex_q.memtoreg;
    assign ex_regwrite   = ex_q.regwrite;
    assign ex_memread    = ex_q.memread;
    assign ex_memwrite   = ex_q.memwrite;
    assign ex_branch     = ex_q.branch;
    assign ex_rd         = ex_q.rd;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
    assign ex_funct3     = ex_q.funct3;

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Bench for id_ctrl_pipe: directed scenarios plus randomized traffic against a
// reference model, on a hazard/pulse instance (a) and a no-hazard/sticky instance (b).
module tb_id_ctrl_pipe;

    typedef struct packed {
        logic       v;
        logic [3:0] alu;
        logic       alusrc, m2r, rw, mr, mw, br;
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        logic       ill;
    } st_t;

    localparam logic [3:0] R_ALU [8] = '{4'd2, 4'd4, 4'd8, 4'd9, 4'd3, 4'd5, 4'd1, 4'd0};
    localparam bit HZ  [2] = '{1'b1, 1'b0};
    localparam bit STK [2] = '{1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        rst, ivalid, flush, stall_in;
    logic [31:0] instr;

    logic       a_stall_out, a_ex_valid, a_ex_alusrc, a_ex_memtoreg, a_ex_regwrite;
    logic       a_ex_memread, a_ex_memwrite, a_ex_branch, a_illegal_flag;
    logic [3:0] a_ex_alucontrol;
    logic [4:0] a_ex_rd, a_ex_rs1, a_ex_rs2;
    logic [2:0] a_ex_funct3;
    logic       b_stall_out, b_ex_valid, b_ex_alusrc, b_ex_memtoreg, b_ex_regwrite;
    logic       b_ex_memread, b_ex_memwrite, b_ex_branch, b_illegal_flag;
    logic [3:0] b_ex_alucontrol;
    logic [4:0] b_ex_rd, b_ex_rs1, b_ex_rs2;
    logic [2:0] b_ex_funct3;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_ctrl_pipe #(.HAZARD_EN(1'b1), .STICKY_ILLEGAL(1'b0)) dut_a (
        .clk(clk), .rst(rst), .instr_in(instr), .instr_valid(ivalid), .flush(flush),
        .stall_in(stall_in), .stall_out(a_stall_out), .ex_valid(a_ex_valid),
        .ex_alucontrol(a_ex_alucontrol), .ex_alusrc(a_ex_alusrc), .ex_memtoreg(a_ex_memtoreg),
        .ex_regwrite(a_ex_regwrite), .ex_memread(a_ex_memread), .ex_memwrite(a_ex_memwrite),
        .ex_branch(a_ex_branch), .ex_rd(a_ex_rd), .ex_rs1(a_ex_rs1), .ex_rs2(a_ex_rs2),
        .ex_funct3(a_ex_funct3), .illegal_flag(a_illegal_flag));

    id_ctrl_pipe #(.HAZARD_EN(1'b0), .STICKY_ILLEGAL(1'b1)) dut_b (
        .clk(clk), .rst(rst), .instr_in(instr), .instr_valid(ivalid), .flush(flush),
        .stall_in(stall_in), .stall_out(b_stall_out), .ex_valid(b_ex_valid),
        .ex_alucontrol(b_ex_alucontrol), .ex_alusrc(b_ex_alusrc), .ex_memtoreg(b_ex_memtoreg),
        .ex_regwrite(b_ex_regwrite), .ex_memread(b_ex_memread), .ex_memwrite(b_ex_memwrite),
        .ex_branch(b_ex_branch), .ex_rd(b_ex_rd), .ex_rs1(b_ex_rs1), .ex_rs2(b_ex_rs2),
        .ex_funct3(b_ex_funct3), .illegal_flag(b_illegal_flag));

    st_t  obs [2];
    logic stall_obs [2];
    assign obs[0] = {a_ex_valid, a_ex_alucontrol, a_ex_alusrc, a_ex_memtoreg, a_ex_regwrite,
                     a_ex_memread, a_ex_memwrite, a_ex_branch, a_ex_rd, a_ex_rs1, a_ex_rs2,
                     a_ex_funct3, a_illegal_flag};
    assign obs[1] = {b_ex_valid, b_ex_alucontrol, b_ex_alusrc, b_ex_memtoreg, b_ex_regwrite,
                     b_ex_memread, b_ex_memwrite, b_ex_branch, b_ex_rd, b_ex_rs1, b_ex_rs2,
                     b_ex_funct3, b_illegal_flag};
    assign stall_obs[0] = a_stall_out;
    assign stall_obs[1] = b_stall_out;

    task automatic set_in(input logic [31:0] i, input logic v, input logic f, input logic s);
        instr = i; ivalid = v; flush = f; stall_in = s;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decode: what EX should hold for a valid instruction, whether it is legal,
    // and which source registers it reads.
    function automatic void ref_decode(input logic [31:0] i, output st_t d, output bit ok,
                                       output bit u1, output bit u2);
        logic [6:0] op = i[6:0];
        logic [2:0] f3 = i[14:12];
        logic [6:0] f7 = i[31:25];
        bit wr = 0;
        d = '0; ok = 0; u1 = 0; u2 = 0;
        d.v = 1; d.rd = i[11:7]; d.rs1 = i[19:15]; d.rs2 = i[24:20]; d.f3 = f3; d.alu = 4'd2;
        if (op == 7'h33) begin
            u1 = 1; u2 = 1; wr = 1;
            ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
            d.alu = (f7 == 7'h20) ? ((f3 == 0) ? 4'd6 : 4'd7) : R_ALU[f3];
        end else if (op == 7'h13) begin
            u1 = 1; wr = 1; d.alusrc = 1;
            ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
            d.alu = (f3 == 5 && f7 == 7'h20) ? 4'd7 : R_ALU[f3];
        end else if (op == 7'h03) begin
            u1 = 1; wr = 1; d.alusrc = 1; d.mr = 1; d.m2r = 1;
            ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        end else if (op == 7'h23) begin
            u1 = 1; u2 = 1; d.alusrc = 1; d.mw = 1;
            ok = (f3 <= 2);
        end else if (op == 7'h63) begin
            u1 = 1; u2 = 1; d.br = 1; d.alu = 4'd6;
            ok = !(f3 inside {3'd2, 3'd3});
        end
        d.rw = wr && (d.rd != 0);
    endfunction

    function automatic logic [31:0] rand_instr();
        int c = $urandom_range(0, 8);
        logic [6:0] op, f7;
        int s = $urandom_range(0, 3);
        case (c)
            0, 1:    op = 7'h33;
            2:       op = 7'h13;
            3, 4:    op = 7'h03;
            5:       op = 7'h23;
            6:       op = 7'h63;
            7:       op = 7'($urandom);
            default: return $urandom;
        endcase
        f7 = (s == 0) ? 7'h00 : (s == 3) ? 7'($urandom) : 7'h20;
        return {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
                5'($urandom_range(0, 7)), op};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        set_in(32'h00000033, 1'b1, 1'b0, 1'b0);
        tick(); tick();
        n_run++;
        if ({obs[0], a_stall_out} !== '0 || {obs[1], b_stall_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got a=%h b=%h want all zero", obs[0], obs[1]);
        end
        rst = 1'b0;
        tick();
        n_run++;
        if ({a_ex_valid, a_ex_alucontrol, a_ex_regwrite} !== {1'b1, 4'b0010, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_first_issue got v=%b alu=%b rw=%b want 1 0010 0",
                     a_ex_valid, a_ex_alucontrol, a_ex_regwrite);
        end
    endtask

    task automatic test_decode();
        set_in(32'h402081B3, 1'b1, 1'b0, 1'b0);
        tick();
        n_run++;
        if ({a_ex_alucontrol, a_ex_alusrc, a_ex_regwrite, a_ex_rd} !== {4'b0110, 1'b0, 1'b1, 5'd3}) begin
            n_fail++;
            $display("FAIL dec_sub got alu=%b src=%b rw=%b rd=%0d want 0110 0 1 3",
                     a_ex_alucontrol, a_ex_alusrc, a_ex_regwrite, a_ex_rd);
        end
        set_in(32'h40335293, 1'b1, 1'b0, 1'b0);
        tick();
        n_run++;
        if ({a_ex_alucontrol, a_ex_alusrc} !== {4'b0111, 1'b1}) begin
            n_fail++;
            $display("FAIL dec_srai got alu=%b src=%b want 0111 1", a_ex_alucontrol, a_ex_alusrc);
        end
        set_in(32'h40008093, 1'b1, 1'b0, 1'b0);
        tick();
        n_run++;
        if ({a_ex_valid, a_ex_alucontrol, a_ex_alusrc} !== {1'b1, 4'b0010, 1'b1}) begin
            n_fail++;
            $display("FAIL dec_addi_bit30 got v=%b alu=%b src=%b want 1 0010 1",
                     a_ex_valid, a_ex_alucontrol, a_ex_alusrc);
        end
    endtask

    task automatic test_load_use();
        set_in(32'h0000A283, 1'b1, 1'b0, 1'b0);
        n_run++;
        if (a_stall_out !== 1'b0) begin
            n_fail++; $display("FAIL lu_no_stall_lw got %b want 0", a_stall_out);
        end
        tick();
        n_run++;
        if ({a_ex_memread, a_ex_memtoreg, a_ex_regwrite, a_ex_rd} !== {1'b1, 1'b1, 1'b1, 5'd5}) begin
            n_fail++;
            $display("FAIL lu_load_ex got mr=%b m2r=%b rw=%b rd=%0d want 1 1 1 5",
                     a_ex_memread, a_ex_memtoreg, a_ex_regwrite, a_ex_rd);
        end
        set_in(32'h00728333, 1'b1, 1'b0, 1'b0);
        n_run++;
        if ({a_stall_out, b_stall_out} !== 2'b10) begin
            n_fail++; $display("FAIL lu_stall got a=%b b=%b want 1 0", a_stall_out, b_stall_out);
        end
        tick();
        n_run++;
        if ({a_ex_valid, a_ex_memread, a_stall_out, b_ex_valid, b_ex_rs1} !== {3'b000, 1'b1, 5'd5}) begin
            n_fail++;
            $display("FAIL lu_bubble got a_v=%b a_mr=%b a_stall=%b b_v=%b b_rs1=%0d want 0 0 0 1 5",
                     a_ex_valid, a_ex_memread, a_stall_out, b_ex_valid, b_ex_rs1);
        end
        tick();
        n_run++;
        if ({a_ex_valid, a_ex_rs1, a_ex_rs2, a_ex_rd, a_ex_alucontrol} !== {1'b1, 5'd5, 5'd7, 5'd6, 4'b0010}) begin
            n_fail++;
            $display("FAIL lu_issue got v=%b rs1=%0d rs2=%0d rd=%0d alu=%b want 1 5 7 6 0010",
                     a_ex_valid, a_ex_rs1, a_ex_rs2, a_ex_rd, a_ex_alucontrol);
        end
    endtask

    task automatic test_back_pressure();
        set_in(32'h0020A223, 1'b1, 1'b0, 1'b0);
        tick();
        n_run++;
        if ({a_ex_valid, a_ex_memwrite, a_ex_regwrite, a_ex_funct3} !== {1'b1, 1'b1, 1'b0, 3'd2}) begin
            n_fail++;
            $display("FAIL bp_store got v=%b mw=%b rw=%b f3=%0d want 1 1 0 2",
                     a_ex_valid, a_ex_memwrite, a_ex_regwrite, a_ex_funct3);
        end
        for (int c = 0; c < 3; c++) begin
            set_in(32'h402081B3, 1'b1, 1'b0, 1'b1);
            tick();
            n_run++;
            if ({a_stall_out, a_ex_valid, a_ex_memwrite, a_ex_alucontrol} !== {1'b0, 1'b1, 1'b1, 4'b0010}) begin
                n_fail++;
                $display("FAIL bp_hold%0d got stall=%b v=%b mw=%b alu=%b want 0 1 1 0010",
                         c, a_stall_out, a_ex_valid, a_ex_memwrite, a_ex_alucontrol);
            end
        end
        set_in(32'h402081B3, 1'b1, 1'b0, 1'b0);
        tick();
        n_run++;
        if ({a_ex_valid, a_ex_memwrite, a_ex_alucontrol} !== {1'b1, 1'b0, 4'b0110}) begin
            n_fail++;
            $display("FAIL bp_release got v=%b mw=%b alu=%b want 1 0 0110",
                     a_ex_valid, a_ex_memwrite, a_ex_alucontrol);
        end
        set_in(32'h0000A283, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(32'h00728333, 1'b1, 1'b0, 1'b1);
        n_run++;
        if (a_stall_out !== 1'b0) begin
            n_fail++; $display("FAIL bp_held_load_stall got %b want 0", a_stall_out);
        end
        tick();
        set_in(32'h00728333, 1'b1, 1'b0, 1'b0);
        n_run++;
        if ({a_ex_memread, a_ex_rd, a_stall_out} !== {1'b1, 5'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL bp_load_after_hold got mr=%b rd=%0d stall=%b want 1 5 1",
                     a_ex_memread, a_ex_rd, a_stall_out);
        end
        tick();
    endtask

    task automatic test_flush();
        set_in(32'h00208463, 1'b1, 1'b1, 1'b0);
        tick();
        n_run++;
        if ({a_ex_valid, a_ex_branch} !== 2'b00) begin
            n_fail++; $display("FAIL fl_beq got v=%b br=%b want 0 0", a_ex_valid, a_ex_branch);
        end
        set_in(32'h00208463, 1'b1, 1'b0, 1'b0);
        tick();
        n_run++;
        if ({a_ex_valid, a_ex_branch, a_ex_alucontrol, a_ex_alusrc, a_ex_regwrite} !== {2'b11, 4'b0110, 2'b00}) begin
            n_fail++;
            $display("FAIL fl_beq_issue got v=%b br=%b alu=%b src=%b rw=%b want 1 1 0110 0 0",
                     a_ex_valid, a_ex_branch, a_ex_alucontrol, a_ex_alusrc, a_ex_regwrite);
        end
        set_in(32'h402081B3, 1'b1, 1'b1, 1'b1);
        tick();
        n_run++;
        if ({a_ex_valid, a_ex_branch, b_ex_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL fl_with_stall_in got a_v=%b a_br=%b b_v=%b want 0 0 0", a_ex_valid, a_ex_branch, b_ex_valid);
        end
        set_in(32'h0000A283, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(32'h00728333, 1'b1, 1'b1, 1'b0);
        n_run++;
        if (a_stall_out !== 1'b1) begin
            n_fail++; $display("FAIL fl_hazard_stall got %b want 1", a_stall_out);
        end
        tick();
        n_run++;
        if (a_ex_valid !== 1'b0) begin
            n_fail++; $display("FAIL fl_hazard_bubble got v=%b want 0", a_ex_valid);
        end
    endtask

    task automatic test_illegal();
        set_in(32'h00000013, 1'b1, 1'b0, 1'b0);
        tick();
        n_run++;
        if ({a_illegal_flag, b_illegal_flag} !== 2'b00) begin
            n_fail++; $display("FAIL il_clean got a=%b b=%b want 0 0", a_illegal_flag, b_illegal_flag);
        end
        set_in(32'h0000007F, 1'b1, 1'b0, 1'b0);
        tick();
        n_run++;
        if ({a_ex_valid, a_ex_regwrite, a_illegal_flag, b_illegal_flag} !== 4'b0011) begin
            n_fail++;
            $display("FAIL il_opcode got v=%b rw=%b a_flag=%b b_flag=%b want 0 0 1 1",
                     a_ex_valid, a_ex_regwrite, a_illegal_flag, b_illegal_flag);
        end
        set_in(32'h00000013, 1'b1, 1'b0, 1'b0);
        tick();
        n_run++;
        if ({a_illegal_flag, b_illegal_flag} !== 2'b01) begin
            n_fail++; $display("FAIL il_pulse_sticky got a=%b b=%b want 0 1", a_illegal_flag, b_illegal_flag);
        end
        set_in(32'h022080B3, 1'b1, 1'b0, 1'b0);
        tick();
        n_run++;
        if ({a_ex_valid, a_illegal_flag} !== 2'b01) begin
            n_fail++; $display("FAIL il_funct7 got v=%b flag=%b want 0 1", a_ex_valid, a_illegal_flag);
        end
        set_in(32'h0000007F, 1'b1, 1'b0, 1'b1);
        tick();
        set_in(32'h0000007F, 1'b1, 1'b1, 1'b0);
        n_run++;
        if (a_illegal_flag !== 1'b0) begin
            n_fail++; $display("FAIL il_under_stall got %b want 0", a_illegal_flag);
        end
        tick();
        set_in(32'h0000007F, 1'b0, 1'b0, 1'b0);
        n_run++;
        if (a_illegal_flag !== 1'b0) begin
            n_fail++; $display("FAIL il_under_flush got %b want 0", a_illegal_flag);
        end
        tick();
        n_run++;
        if ({a_illegal_flag, a_ex_valid, b_illegal_flag} !== 3'b001) begin
            n_fail++;
            $display("FAIL il_invalid got a_flag=%b a_v=%b b_flag=%b want 0 0 1",
                     a_illegal_flag, a_ex_valid, b_illegal_flag);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_run++;
        if (b_illegal_flag !== 1'b0) begin
            n_fail++; $display("FAIL il_sticky_reset got %b want 0", b_illegal_flag);
        end
    endtask

    task automatic test_random();
        st_t         m [2];
        st_t         d, nm;
        bit          ok, u1, u2, hz, exp_stall, newill, held;
        logic [31:0] ri;
        rst = 1'b1;
        set_in(32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        m[0] = '0; m[1] = '0;
        held = 0;
        ri = 32'h0;
        for (int n = 0; n < 800; n++) begin
            // emulate IF/ID holding the instruction while a load-use stall is pending
            if (!held) ri = rand_instr();
            rst = ($urandom_range(0, 99) == 0);
            set_in(ri, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
            ref_decode(instr, d, ok, u1, u2);
            held = 0;
            for (int k = 0; k < 2; k++) begin
                hz = HZ[k] && m[k].v && m[k].mr && (m[k].rd != 0) && ivalid &&
                     ((u1 && m[k].rd == d.rs1) || (u2 && m[k].rd == d.rs2));
                exp_stall = hz && !stall_in && !rst;
                if (k == 0) held = exp_stall;
                n_run++;
                if (stall_obs[k] !== exp_stall) begin
                    n_fail++;
                    $display("FAIL rnd_stall dut%0d cyc%0d instr=%h got %b want %b",
                             k, n, instr, stall_obs[k], exp_stall);
                end
                nm = m[k];
                if (rst) nm = '0;
                else if (flush || (!stall_in && hz)) begin
                    nm = '0;
                    nm.ill = STK[k] && m[k].ill;
                end else if (stall_in) nm.ill = STK[k] && m[k].ill;
                else begin
                    newill = ivalid && !ok;
                    nm = (ivalid && ok) ? d : '0;
                    nm.ill = STK[k] ? (m[k].ill || newill) : newill;
                end
                m[k] = nm;
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                n_run++;
                if (obs[k] !== m[k]) begin
                    n_fail++;
                    $display("FAIL rnd_bundle dut%0d cyc%0d instr=%h got %h want %h",
                             k, n, instr, obs[k], m[k]);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_load_use();
        test_back_pressure();
        test_flush();
        test_illegal();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
